// File: rtl/acq_sequencer.sv
// acq_sequencer: clocked PSEC6 acquisition sequencer.
// Sequence: channel reset -> armed (sampling clock on) -> trigger -> post-trigger
// delay -> per-channel readout over a req/done handshake -> done pulse.
// Every output except state is registered from the next-state decision, so each
// output is aligned with the state it belongs to.
module acq_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int RST_CYC = 4,
    parameter int DLY_W   = 8,
    parameter int TMO_CYC = 1024,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    input  logic              trig,
    input  logic [DLY_W-1:0]  post_trig_dly,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              ch_rd_done,
    output logic              inst_rst,
    output logic              inst_start,
    output logic              clk_enable,
    output logic [CH_W-1:0]   ch_sel,
    output logic              ch_rd_req,
    output logic              busy,
    output logic              done,
    output logic              tmo_err,
    output logic [2:0]        state
);

    localparam int PTR_W   = $clog2(NUM_CH + 1);
    localparam int DLY_MAX = (1 << DLY_W) - 1;
    localparam int CNT_A   = (RST_CYC > TMO_CYC) ? RST_CYC : TMO_CYC;
    localparam int CNT_MAX = (CNT_A > DLY_MAX) ? CNT_A : DLY_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST      = 3'd1,
        S_ARMED    = 3'd2,
        S_POSTTRIG = 3'd3,
        S_READOUT  = 3'd4,
        S_WAITCH   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_start, w_start;
    logic [PTR_W-1:0]  r_ptr, w_ptr;
    logic [NUM_CH-1:0] r_mask, w_mask;
    logic [CH_W-1:0]   r_ch_sel, w_ch_sel;
    logic              r_tmo_err, w_tmo_err;
    logic              r_inst_rst, r_inst_start, r_clk_en, r_rd_req, r_busy, r_done;
    logic              w_found;
    logic [CH_W-1:0]   w_idx;
    logic [PTR_W-1:0]  w_ptr_adv;
    logic              w_abort;

    assign inst_rst   = r_inst_rst;
    assign inst_start = r_inst_start;
    assign clk_enable = r_clk_en;
    assign ch_sel     = r_ch_sel;
    assign ch_rd_req  = r_rd_req;
    assign busy       = r_busy;
    assign done       = r_done;
    assign tmo_err    = r_tmo_err;
    assign state      = r_state;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state;
    end

    // Channel scan: lowest enabled channel at or above the pointer
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!w_found && r_mask[i] && (i >= 32'(r_ptr))) begin
                w_found = 1'b1;
                w_idx   = CH_W'(i);
            end
        end
        w_ptr_adv = PTR_W'(r_ch_sel) + PTR_W'(1);
    end

    // Next-state and next-register logic
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_start   = r_start;
        w_ptr     = r_ptr;
        w_mask    = r_mask;
        w_ch_sel  = r_ch_sel;
        w_tmo_err = r_tmo_err;
        w_abort   = cmd_valid && (cmd == 2'd1) && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        2'd1, 2'd3: begin
                            w_state   = S_RST;
                            w_cnt     = '0;
                            w_start   = (cmd == 2'd3);
                            w_tmo_err = 1'b0;
                        end
                        2'd2: begin
                            w_state = S_READOUT;
                            w_mask  = ch_mask;
                            w_ptr   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_RST: begin
                if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                    w_state = r_start ? S_ARMED : S_IDLE;
                    w_start = 1'b0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_ARMED: begin
                // r_inst_start is high only in the first ARMED cycle, which masks trig there
                if (trig && !r_inst_start) begin
                    w_state = S_POSTTRIG;
                    w_cnt   = CNT_W'(post_trig_dly);
                end
            end
            S_POSTTRIG: begin
                // Leaving at count 1 gives post_trig_dly cycles here, minimum one
                if (r_cnt <= CNT_W'(1)) begin
                    w_state = S_READOUT;
                    w_mask  = ch_mask;
                    w_ptr   = '0;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_READOUT: begin
                if (w_found) begin
                    w_state  = S_WAITCH;
                    w_ch_sel = w_idx;
                    w_cnt    = '0;
                end else begin
                    w_state = S_DONE;
                end
            end
            S_WAITCH: begin
                if (ch_rd_done) begin
                    w_state = S_READOUT;
                    w_ptr   = w_ptr_adv;
                end else if (r_cnt == CNT_W'(TMO_CYC - 1)) begin
                    w_state   = S_READOUT;
                    w_ptr     = w_ptr_adv;
                    w_tmo_err = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        if (w_abort) begin
            w_state   = S_RST;
            w_cnt     = '0;
            w_start   = 1'b0;
            w_tmo_err = 1'b0;
        end
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt        <= '0;
            r_start      <= 1'b0;
            r_ptr        <= '0;
            r_mask       <= '0;
            r_ch_sel     <= '0;
            r_tmo_err    <= 1'b0;
            r_inst_rst   <= 1'b0;
            r_inst_start <= 1'b0;
            r_clk_en     <= 1'b0;
            r_rd_req     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cnt        <= w_cnt;
            r_start      <= w_start;
            r_ptr        <= w_ptr;
            r_mask       <= w_mask;
            r_ch_sel     <= w_ch_sel;
            r_tmo_err    <= w_tmo_err;
            r_inst_rst   <= (w_state == S_RST);
            r_inst_start <= (w_state == S_ARMED) && (r_state != S_ARMED);
            r_clk_en     <= (w_state == S_ARMED);
            r_rd_req     <= (w_state == S_WAITCH);
            r_busy       <= (w_state != S_IDLE);
            r_done       <= (w_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed scenarios for acq_sequencer with hand-computed expectations.
module tb_acq_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       trig = 1'b0;
    logic [7:0] post_trig_dly = 8'd0;
    logic [7:0] ch_mask = 8'd0;
    logic       ch_rd_done = 1'b0;
    logic       inst_rst, inst_start, clk_enable, ch_rd_req, busy, done, tmo_err;
    logic [2:0] ch_sel;
    logic [2:0] state;

    int n_asserts = 0;
    int n_fail    = 0;

    acq_sequencer #(.NUM_CH(8), .RST_CYC(4), .DLY_W(8), .TMO_CYC(1024)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd(cmd), .trig(trig),
        .post_trig_dly(post_trig_dly), .ch_mask(ch_mask), .ch_rd_done(ch_rd_done),
        .inst_rst(inst_rst), .inst_start(inst_start), .clk_enable(clk_enable),
        .ch_sel(ch_sel), .ch_rd_req(ch_rd_req), .busy(busy), .done(done),
        .tmo_err(tmo_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion within 1 ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (state === s) ok = 1'b1;
            else tick();
        end
        if (state === s) ok = 1'b1;
    endtask

    task automatic issue_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        cmd       = 2'd0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(); tick();
        n_asserts++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_asserts++;
        if ({inst_rst, inst_start, clk_enable, ch_rd_req, busy, done, tmo_err} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {inst_rst, inst_start, clk_enable, ch_rd_req, busy, done, tmo_err});
        end
        n_asserts++;
        if (ch_sel !== 3'd0) begin n_fail++; $display("FAIL reset_ch_sel: got %0d expected 0", ch_sel); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_start();
        int n;
        post_trig_dly = 8'd5;
        ch_mask       = 8'b1010_0100;
        issue_cmd(2'd3);
        n_asserts++;
        if (state !== 3'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL start_rst_entry: state=%0d busy=%b expected state=1 busy=1", state, busy);
        end
        n = 0;
        while (inst_rst === 1'b1 && n < 20) begin n++; tick(); end
        n_asserts++;
        if (n !== 4) begin n_fail++; $display("FAIL start_rst_width: got %0d cycles expected 4", n); end
        n_asserts++;
        if (inst_start !== 1'b1 || clk_enable !== 1'b1) begin
            n_fail++; $display("FAIL start_first_armed: inst_start=%b clk_enable=%b expected 1 1", inst_start, clk_enable);
        end
        n_asserts++;
        if (state !== 3'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL start_armed_state: state=%0d busy=%b expected 2 1", state, busy);
        end
        tick();
        n_asserts++;
        if (inst_start !== 1'b0 || clk_enable !== 1'b1) begin
            n_fail++; $display("FAIL start_pulse_width: inst_start=%b clk_enable=%b expected 0 1", inst_start, clk_enable);
        end
        issue_cmd(2'd2);
        n_asserts++;
        if (state !== 3'd2) begin n_fail++; $display("FAIL busy_cmd_ignored: state=%0d expected 2", state); end
    endtask

    task automatic test_trigger();
        int n, npost;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        n_asserts++;
        if (clk_enable !== 1'b0 || state !== 3'd3) begin
            n_fail++; $display("FAIL trig_clk_off: clk_enable=%b state=%0d expected 0 3", clk_enable, state);
        end
        n = 0; npost = 0;
        while (ch_rd_req !== 1'b1 && n < 50) begin
            if (state === 3'd3) npost++;
            n++;
            tick();
        end
        n_asserts++;
        if (npost !== 5) begin n_fail++; $display("FAIL posttrig_len: got %0d cycles expected 5", npost); end
        n_asserts++;
        if (n !== 6) begin n_fail++; $display("FAIL req_latency: got %0d cycles expected 6", n); end
    endtask

    task automatic test_mask_readout();
        int exp_ch[3] = '{2, 5, 7};
        for (int k = 0; k < 3; k++) begin
            n_asserts++;
            if (ch_rd_req !== 1'b1 || ch_sel !== 3'(exp_ch[k])) begin
                n_fail++; $display("FAIL mask_req_%0d: req=%b ch_sel=%0d expected 1 %0d", k, ch_rd_req, ch_sel, exp_ch[k]);
            end
            tick(); tick(); tick();
            n_asserts++;
            if (ch_rd_req !== 1'b1 || ch_sel !== 3'(exp_ch[k]) || state !== 3'd5) begin
                n_fail++; $display("FAIL mask_hold_%0d: req=%b ch_sel=%0d state=%0d expected 1 %0d 5",
                                   k, ch_rd_req, ch_sel, state, exp_ch[k]);
            end
            ch_rd_done = 1'b1;
            tick();
            ch_rd_done = 1'b0;
            n_asserts++;
            if (ch_rd_req !== 1'b0 || state !== 3'd4) begin
                n_fail++; $display("FAIL mask_gap_%0d: req=%b state=%0d expected 0 4", k, ch_rd_req, state);
            end
            tick();
        end
        n_asserts++;
        if (done !== 1'b1 || state !== 3'd6) begin
            n_fail++; $display("FAIL mask_done: done=%b state=%0d expected 1 6", done, state);
        end
        tick();
        n_asserts++;
        if (done !== 1'b0 || state !== 3'd0 || busy !== 1'b0 || tmo_err !== 1'b0) begin
            n_fail++; $display("FAIL mask_idle: done=%b state=%0d busy=%b tmo_err=%b expected 0 0 0 0",
                               done, state, busy, tmo_err);
        end
    endtask

    task automatic test_readout_empty();
        ch_mask = 8'd0;
        issue_cmd(2'd2);
        n_asserts++;
        if (state !== 3'd4 || ch_rd_req !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL empty_readout: state=%0d req=%b done=%b expected 4 0 0", state, ch_rd_req, done);
        end
        tick();
        n_asserts++;
        if (state !== 3'd6 || done !== 1'b1 || ch_rd_req !== 1'b0) begin
            n_fail++; $display("FAIL empty_done: state=%0d done=%b req=%b expected 6 1 0", state, done, ch_rd_req);
        end
        tick();
        n_asserts++;
        if (state !== 3'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL empty_idle: state=%0d done=%b expected 0 0", state, done);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        ch_mask = 8'b0000_0011;
        issue_cmd(2'd2);
        tick();
        n = 0;
        while (state === 3'd5 && n < 2000) begin n++; tick(); end
        n_asserts++;
        if (n !== 1024) begin n_fail++; $display("FAIL tmo_wait_len: got %0d cycles expected 1024", n); end
        n_asserts++;
        if (tmo_err !== 1'b1 || ch_rd_req !== 1'b0 || state !== 3'd4) begin
            n_fail++; $display("FAIL tmo_flag: tmo_err=%b req=%b state=%0d expected 1 0 4", tmo_err, ch_rd_req, state);
        end
        tick();
        n_asserts++;
        if (ch_rd_req !== 1'b1 || ch_sel !== 3'd1) begin
            n_fail++; $display("FAIL tmo_next_ch: req=%b ch_sel=%0d expected 1 1", ch_rd_req, ch_sel);
        end
        ch_rd_done = 1'b1;
        tick();
        ch_rd_done = 1'b0;
        tick(); tick();
        n_asserts++;
        if (state !== 3'd0 || tmo_err !== 1'b1) begin
            n_fail++; $display("FAIL tmo_sticky: state=%0d tmo_err=%b expected 0 1", state, tmo_err);
        end
        issue_cmd(2'd1);
        n_asserts++;
        if (state !== 3'd1 || tmo_err !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear: state=%0d tmo_err=%b expected 1 0", state, tmo_err);
        end
        wait_state(3'd0, 10, ok);
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL rst_only_return: state=%0d expected 0", state); end
    endtask

    task automatic test_done_at_timeout();
        ch_mask = 8'b0000_0001;
        issue_cmd(2'd2);
        tick();
        for (int i = 0; i < 1023; i++) tick();
        n_asserts++;
        if (state !== 3'd5 || ch_rd_req !== 1'b1) begin
            n_fail++; $display("FAIL edge_still_wait: state=%0d req=%b expected 5 1", state, ch_rd_req);
        end
        ch_rd_done = 1'b1;
        tick();
        ch_rd_done = 1'b0;
        n_asserts++;
        if (state !== 3'd4 || tmo_err !== 1'b0) begin
            n_fail++; $display("FAIL edge_done_wins: state=%0d tmo_err=%b expected 4 0", state, tmo_err);
        end
        tick(); tick();
    endtask

    task automatic test_abort();
        bit saw_done;
        bit ok;
        ch_mask = 8'b0001_0000;
        issue_cmd(2'd2);
        tick();
        n_asserts++;
        if (ch_sel !== 3'd4 || ch_rd_req !== 1'b1) begin
            n_fail++; $display("FAIL abort_setup: ch_sel=%0d req=%b expected 4 1", ch_sel, ch_rd_req);
        end
        tick();
        issue_cmd(2'd1);
        n_asserts++;
        if (state !== 3'd1 || ch_rd_req !== 1'b0 || inst_rst !== 1'b1 || clk_enable !== 1'b0) begin
            n_fail++; $display("FAIL abort_next: state=%0d req=%b inst_rst=%b clk_en=%b expected 1 0 1 0",
                               state, ch_rd_req, inst_rst, clk_enable);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_asserts++;
        if (saw_done !== 1'b0 || state !== 3'd0) begin
            n_fail++; $display("FAIL abort_no_done: saw_done=%b state=%0d expected 0 0", saw_done, state);
        end
        wait_state(3'd0, 2, ok);
    endtask

    task automatic test_dly_zero();
        bit ok;
        post_trig_dly = 8'd0;
        ch_mask       = 8'd0;
        issue_cmd(2'd3);
        trig = 1'b1;
        wait_state(3'd2, 20, ok);
        n_asserts++;
        if (!ok || inst_start !== 1'b1) begin
            n_fail++; $display("FAIL dz_armed: state=%0d inst_start=%b expected 2 1", state, inst_start);
        end
        tick();
        n_asserts++;
        if (state !== 3'd2 || clk_enable !== 1'b1) begin
            n_fail++; $display("FAIL dz_first_trig_ignored: state=%0d clk_en=%b expected 2 1", state, clk_enable);
        end
        tick();
        trig = 1'b0;
        n_asserts++;
        if (state !== 3'd3 || clk_enable !== 1'b0) begin
            n_fail++; $display("FAIL dz_posttrig: state=%0d clk_en=%b expected 3 0", state, clk_enable);
        end
        tick();
        n_asserts++;
        if (state !== 3'd4) begin n_fail++; $display("FAIL dz_one_cycle: state=%0d expected 4", state); end
        tick();
        n_asserts++;
        if (state !== 3'd6 || done !== 1'b1) begin
            n_fail++; $display("FAIL dz_done: state=%0d done=%b expected 6 1", state, done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bit ok;
        post_trig_dly = 8'd50;
        issue_cmd(2'd3);
        wait_state(3'd2, 20, ok);
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        n_asserts++;
        if (state !== 3'd3 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ar_setup: state=%0d busy=%b expected 3 1", state, busy);
        end
        #2 rstn = 1'b0;
        #1;
        n_asserts++;
        if (state !== 3'd0 || {inst_rst, inst_start, clk_enable, ch_rd_req, busy, done, tmo_err} !== 7'd0
            || ch_sel !== 3'd0) begin
            n_fail++; $display("FAIL ar_clear: state=%0d outs=%b ch_sel=%0d expected 0 0000000 0", state,
                               {inst_rst, inst_start, clk_enable, ch_rd_req, busy, done, tmo_err}, ch_sel);
        end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_start();
        test_trigger();
        test_mask_readout();
        test_readout_empty();
        test_timeout();
        test_done_at_timeout();
        test_abort();
        test_dly_zero();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Clocked sequencer for one PSEC6 acquisition cycle, from channel reset through the final channel readout. Sequence: reset the channels, enable the sampling clock, wait for a trigger, apply a programmable post-trigger delay, then issue readout requests to each enabled channel in turn over a req/done handshake. The block sits between the SPI register file (commands, delay, channel mask) and the per-channel instruction inputs. It replaces the asynchronous cs-width pulse scheme with fixed-width, clocked pulses.

Parameters:
NUM_CH, 8, number of channels sequenced; ch_sel width is CH_W = max(1, clog2(NUM_CH))
RST_CYC, 4, inst_rst pulse width in clk cycles (>=1)
DLY_W, 8, width of post_trig_dly
TMO_CYC, 1024, maximum cycles to wait for ch_rd_done before skipping a channel

Ports:
clk  input  1  sequencer clock
rstn  input  1  asynchronous active-low reset
cmd_valid  input  1  one-cycle strobe: cmd is valid
cmd  input  2  0=nop, 1=reset, 2=readout only, 3=start acquisition
trig  input  1  trigger, already synchronous to clk, level-sensitive
post_trig_dly  input  DLY_W  cycles to wait after trigger before readout
ch_mask  input  NUM_CH  1=channel is read out; sampled when READOUT is entered
ch_rd_done  input  1  selected channel has finished its readout
inst_rst  output  1  channel reset pulse
inst_start  output  1  one-cycle start pulse to the channels
clk_enable  output  1  sampling clock enable
ch_sel  output  CH_W  index of the channel being read
ch_rd_req  output  1  readout request to the channel at ch_sel
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a sequence completes
tmo_err  output  1  sticky: a channel timed out; cleared by a cmd=1 or cmd=3 strobe
state  output  3  current state encoding, for debug readback

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; all outputs 0; counters and latched mask cleared.
- States and encodings: IDLE=0, RST=1, ARMED=2, POSTTRIG=3, READOUT=4, WAITCH=5, DONE=6.
- IDLE:
  - cmd 1 -> RST.
  - cmd 3 -> RST, then on to ARMED (start flag set).
  - cmd 2 -> READOUT.
  - cmd 0 -> no action.
- RST: inst_rst=1 for exactly RST_CYC cycles. Then go to IDLE, or go to ARMED if the start flag is set.
- Entering ARMED:
  - inst_start=1 for exactly the first ARMED cycle.
  - clk_enable is registered and goes 1 in the same cycle.
  - trig is ignored during that first cycle.
- ARMED: trig=1 -> clk_enable=0 in the next cycle, delay counter loaded with post_trig_dly, go to POSTTRIG.
- POSTTRIG: count down. When count=0 -> READOUT. If post_trig_dly=0, POSTTRIG lasts exactly 1 cycle.
- READOUT (one cycle):
  - On entry, latch ch_mask.
  - Find the lowest-index set bit at or above the scan pointer.
  - If found: ch_sel=that index, ch_rd_req=1, go to WAITCH.
  - If none: go to DONE.
  - The scan pointer starts at 0 on each sequence.
- WAITCH:
  - ch_rd_req held high, ch_sel stable.
  - ch_rd_done=1 -> ch_rd_req=0 in the next cycle; pointer = ch_sel+1; back to READOUT.
  - If TMO_CYC cycles elapse without ch_rd_done: set tmo_err, drop ch_rd_req, advance the pointer, back to READOUT.
  - If ch_rd_done arrives in the same cycle as the timeout, the done wins and no error is raised.
- DONE: done=1 for one cycle, then IDLE.
- Once pointer=NUM_CH, the next READOUT goes to DONE (no wrap-around).
- cmd=1 in any non-IDLE state aborts the sequence:
  - Next cycle: clk_enable=0, ch_rd_req=0, start flag cleared, go to RST.
  - done is not pulsed.
- cmd=2 or cmd=3 while busy is ignored.
- cmd_valid with cmd=0 is a nop.
- trig outside ARMED is ignored.
- ch_rd_done outside WAITCH is ignored.
- Output timing: all outputs registered except state, which is the state register itself.
- Inter-channel gap: one READOUT cycle between consecutive channels. ch_rd_req is low for at least 1 cycle between channels.

Test Plan:
- Reset then cmd=3: inst_rst high exactly 4 cycles; then inst_start high 1 cycle with clk_enable=1 in that same cycle; state=2, busy=1.
- ARMED, post_trig_dly=5, trig pulse: clk_enable=0 next cycle; ch_rd_req rises 5 POSTTRIG cycles + 1 READOUT cycle after that.
- ch_mask=8'b1010_0100, done returned 3 cycles after each request: ch_sel sequence 2,5,7; then done pulse 1 cycle; state=0, tmo_err=0.
- cmd=2 with ch_mask=0: READOUT then DONE; done pulses 2 cycles after the strobe; no ch_rd_req.
- ch_mask=8'b0000_0011, ch 0 never returns done: after 1024 cycles tmo_err=1 and ch_sel=1 gets its request; tmo_err stays 1 until the next cmd=1.
- Mid-WAITCH cmd=1: next cycle ch_rd_req=0 and state=RST; no done pulse. Separately, asserting rstn low mid-POSTTRIG clears all outputs with no clk edge.
